// File: rtl/bta_pipe_adder.sv
// Pipelined multi-operand binary-tree adder with valid/ready streaming and run accumulation.
// Each tree level is a register stage; the carry-in joins only at the root adder.
module bta_pipe_adder #(
  parameter int N_OPS    = 8,
  parameter int W        = 16,
  parameter int ACC_BITS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [N_OPS*W-1:0]                     ops,
  input  logic                                   cin,
  input  logic                                   acc_en,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [W+$clog2(N_OPS)+ACC_BITS-1:0]    sum,
  output logic                                   out_ovf
);

  localparam int L     = $clog2(N_OPS);
  localparam int OUT_W = W + L + ACC_BITS;

  logic               en_s;
  logic [W+L-1:0]     root_s;
  logic               root_vld_s;
  logic               root_acc_s;
  logic               root_last_s;
  logic [OUT_W:0]     acc_sum_s;
  logic [OUT_W-1:0]   acc_r;
  logic               ovf_acc_r;
  logic [OUT_W-1:0]   sum_r;
  logic               out_valid_r;
  logic               out_ovf_r;

  assign en_s     = !out_valid_r || out_ready;
  assign in_ready = en_s;

  genvar k, j;
  for (k = 0; k <= L; k++) begin : g_lvl
    localparam int NW = W + k;
    localparam int NE = N_OPS >> k;
    // The root drops the carry-in bit because it has already been consumed there.
    localparam int CW = (k == L) ? 3 : 4;
    logic [NE*NW-1:0] val_s;
    logic [CW-1:0]    ctl_s;  // {cin, last, acc, vld}

    if (k == 0) begin : g_src
      assign val_s = ops;
      assign ctl_s = {cin, in_last, acc_en, in_valid};
    end else begin : g_stage
      localparam int PW = NW - 1;
      logic [NE*NW-1:0] nxt_s;
      logic [NE*NW-1:0] data_r;
      logic [CW-1:0]    ctl_r;

      for (j = 0; j < NE; j++) begin : g_add
        if (k == L) begin : g_root
          assign nxt_s[j*NW +: NW] = NW'(g_lvl[k-1].val_s[2*j*PW +: PW])
                                   + NW'(g_lvl[k-1].val_s[(2*j+1)*PW +: PW])
                                   + NW'(g_lvl[k-1].ctl_s[3]);
        end else begin : g_mid
          assign nxt_s[j*NW +: NW] = NW'(g_lvl[k-1].val_s[2*j*PW +: PW])
                                   + NW'(g_lvl[k-1].val_s[(2*j+1)*PW +: PW]);
        end
      end

      // Stage register: partial sums plus the beat's side-band bits, frozen while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_r <= '0;
          ctl_r  <= '0;
        end else if (en_s) begin
          data_r <= nxt_s;
          ctl_r  <= g_lvl[k-1].ctl_s[CW-1:0];
        end
      end

      assign val_s = data_r;
      assign ctl_s = ctl_r;
    end
  end

  assign root_s      = g_lvl[L].val_s;
  assign root_vld_s  = g_lvl[L].ctl_s[0];
  assign root_acc_s  = g_lvl[L].ctl_s[1];
  assign root_last_s = g_lvl[L].ctl_s[2];

  // Accumulator add with one spare bit to expose the modulo wrap.
  always_comb begin
    acc_sum_s = {1'b0, acc_r} + (OUT_W + 1)'(root_s);
  end

  // Output stage: emit single beats, or accumulate a run and emit on its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= '0;
      ovf_acc_r   <= 1'b0;
      sum_r       <= '0;
      out_valid_r <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else if (en_s) begin
      if (root_vld_s && !root_acc_s) begin
        sum_r       <= OUT_W'(root_s);
        out_ovf_r   <= 1'b0;
        out_valid_r <= 1'b1;
      end else if (root_vld_s && root_last_s) begin
        sum_r       <= acc_sum_s[OUT_W-1:0];
        out_ovf_r   <= ovf_acc_r | acc_sum_s[OUT_W];
        out_valid_r <= 1'b1;
        acc_r       <= '0;
        ovf_acc_r   <= 1'b0;
      end else if (root_vld_s) begin
        acc_r       <= acc_sum_s[OUT_W-1:0];
        ovf_acc_r   <= ovf_acc_r | acc_sum_s[OUT_W];
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign sum       = sum_r;
  assign out_valid = out_valid_r;
  assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_bta_pipe_adder.sv
// Self-checking bench: two adders (ACC_BITS=4 and 2) share one stimulus stream and are
// checked against an unbounded-integer scoreboard reduced modulo each output width.
module tb_bta_pipe_adder;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int OW_A = W + 3 + 4;
  localparam int OW_B = W + 3 + 2;

  typedef struct { longint s; bit o; } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [N*W-1:0]    ops;
  logic              cin, acc_en, in_last, out_ready;
  logic              in_ready_a, out_valid_a, out_ovf_a;
  logic              in_ready_b, out_valid_b, out_ovf_b;
  logic [OW_A-1:0]   sum_a;
  logic [OW_B-1:0]   sum_b;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_out_a = 0;
  longint acc_tot = 0;
  exp_t   q_a[$];
  exp_t   q_b[$];

  always #5 clk = ~clk;

  bta_pipe_adder #(.N_OPS(N), .W(W), .ACC_BITS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .ops(ops),
    .cin(cin), .acc_en(acc_en), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .sum(sum_a), .out_ovf(out_ovf_a));

  bta_pipe_adder #(.N_OPS(N), .W(W), .ACC_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .ops(ops),
    .cin(cin), .acc_en(acc_en), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .sum(sum_b), .out_ovf(out_ovf_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] seq_ops(input int base);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(i + 1 + base);
    return v;
  endfunction

  function automatic exp_t reduce(input longint total, input int ow);
    exp_t e;
    longint modv;
    modv = longint'(1) << ow;
    e.s = total % modv;
    e.o = (total >= modv);
    return e;
  endfunction

  // Scoreboard: record accepted beats, compare every output handshake.
  always @(negedge clk) begin
    longint tot;
    exp_t   e;
    if (rst_n) begin
      if (in_valid && in_ready_a) begin
        tot = longint'(cin);
        for (int i = 0; i < N; i++) tot += longint'(ops[i*W +: W]);
        if (!acc_en) begin
          q_a.push_back(reduce(tot, OW_A));
          q_b.push_back(reduce(tot, OW_B));
        end else begin
          acc_tot += tot;
          if (in_last) begin
            q_a.push_back(reduce(acc_tot, OW_A));
            q_b.push_back(reduce(acc_tot, OW_B));
            acc_tot = 0;
          end
        end
      end
      if (out_valid_a && out_ready) begin
        chk("a_expected_output", 64'(q_a.size() != 0), 64'd1);
        if (q_a.size() != 0) begin
          e = q_a.pop_front();
          chk("a_sum", 64'(sum_a), 64'(e.s));
          chk("a_ovf", 64'(out_ovf_a), 64'(e.o));
          n_out_a++;
        end
      end
      if (out_valid_b && out_ready) begin
        chk("b_expected_output", 64'(q_b.size() != 0), 64'd1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          chk("b_sum", 64'(sum_b), 64'(e.s));
          chk("b_ovf", 64'(out_ovf_b), 64'(e.o));
        end
      end
    end
  end

  task automatic send(input logic [N*W-1:0] v, input logic c, input logic a,
                      input logic l, output int tries);
    logic ok;
    in_valid = 1'b1; ops = v; cin = c; acc_en = a; in_last = l;
    tries = 0;
    do begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 200);
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_a", 64'(q_a.size()), 64'd0);
    chk("drain_b", 64'(q_b.size()), 64'd0);
  endtask

  initial begin
    int t, n, base_out;
    logic [N*W-1:0] ones;
    ones = '1;
    rst_n = 1'b0; in_valid = 1'b0; ops = '0; cin = 1'b0; acc_en = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", 64'(sum_a), 64'd0);
    chk("rst_valid", 64'(out_valid_a), 64'd0);
    chk("rst_ovf", 64'(out_ovf_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-ones beat with carry-in; latency counted in edges from presenting the beat.
    in_valid = 1'b1; ops = ones; cin = 1'b1; acc_en = 1'b0; in_last = 1'b0;
    n = 0;
    while (!out_valid_a && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) in_valid = 1'b0;
    end
    chk("latency_edges", 64'(n), 64'd4);
    chk("max_sum_const", 64'(sum_a), 64'd524281);
    drain();

    // Back-to-back stream: every beat accepted on first try, one output each.
    base_out = n_out_a;
    for (int b = 0; b < 10; b++) begin
      send(seq_ops(b), 1'b0, 1'b0, 1'b0, t);
      chk("stream_in_ready", 64'(t), 64'd1);
    end
    drain();
    chk("stream_count", 64'(n_out_a - base_out), 64'd10);

    // Same stream with a 5-cycle downstream stall.
    base_out = n_out_a;
    fork
      begin
        for (int b = 0; b < 10; b++) send(seq_ops(b), 1'b0, 1'b0, 1'b0, t);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          chk("stall_in_ready", 64'(in_ready_a), 64'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", 64'(n_out_a - base_out), 64'd10);

    // Run of 4 beats (144) with an interleaved single all-ones beat (524280).
    send(seq_ops(0), 1'b0, 1'b1, 1'b0, t);
    send(seq_ops(0), 1'b0, 1'b1, 1'b0, t);
    send(ones,       1'b0, 1'b0, 1'b1, t);
    send(seq_ops(0), 1'b0, 1'b1, 1'b0, t);
    send(seq_ops(0), 1'b0, 1'b1, 1'b1, t);
    drain();

    // Five all-ones beats with carry-in: wraps the 21-bit result only.
    for (int b = 0; b < 5; b++) send(ones, 1'b1, 1'b1, 1'(b == 4), t);
    send(seq_ops(0), 1'b0, 1'b1, 1'b1, t);
    drain();

    // Reset with a run open, one result on the output and two beats in flight.
    send(seq_ops(0), 1'b0, 1'b1, 1'b0, t);
    send(ones,       1'b0, 1'b0, 1'b0, t);
    send(seq_ops(1), 1'b0, 1'b1, 1'b0, t);
    send(seq_ops(2), 1'b0, 1'b1, 1'b0, t);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 64'(sum_a), 64'd0);
    chk("mid_rst_valid", 64'(out_valid_a), 64'd0);
    chk("mid_rst_ovf", 64'(out_ovf_a), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready_a), 64'd1);
    q_a.delete(); q_b.delete(); acc_tot = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_stale_output", 64'(out_valid_a), 64'd0);
    send(seq_ops(0), 1'b0, 1'b1, 1'b1, t);
    drain();

    // Random beats and runs under random backpressure.
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          logic [N*W-1:0] v;
          for (int i = 0; i < N; i++) v[i*W +: W] = W'($urandom);
          send(v, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), t);
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    send(seq_ops(3), 1'b1, 1'b1, 1'b1, t);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
